// File: rtl/fwrisc_regfile_sb.sv
// fwrisc_regfile_sb - parametrised register file with busy scoreboard for the
// pipelined fwrisc cores.
//
// After reset a clear sequencer walks every register and writes zero, so
// the array needs no initialisation file. 'ready' rises when the sweep is
// done. Until then, writes, claims and flushes are ignored, and the read
// data and busy outputs stay at zero.
//
// Ports:
//   clock              single clock, rising edge
//   reset              asynchronous, active-low reset
//   ready              high once the clear sequence has completed
//   ra_raddr/rb_raddr  read addresses, sampled every edge
//   ra_rdata/rb_rdata  registered read data, one cycle after the address
//   ra_busy/rb_busy    busy flag of the registered read address
//   rd_waddr/rd_wdata/rd_wen   write port
//   claim_en/claim_addr        mark a register busy (pending producer)
//   flush              clear every busy flag
module fwrisc_regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 64,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset,
  output logic            ready,
  input  logic [AW-1:0]   ra_raddr,
  output logic [XLEN-1:0] ra_rdata,
  output logic            ra_busy,
  input  logic [AW-1:0]   rb_raddr,
  output logic [XLEN-1:0] rb_rdata,
  output logic            rb_busy,
  input  logic [AW-1:0]   rd_waddr,
  input  logic [XLEN-1:0] rd_wdata,
  input  logic            rd_wen,
  input  logic            claim_en,
  input  logic [AW-1:0]   claim_addr,
  input  logic            flush
);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_clr_cnt;
  logic [XLEN-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic [AW-1:0]   r_ra_addr;
  logic [AW-1:0]   r_rb_addr;
  logic [XLEN-1:0] r_ra_data;
  logic [XLEN-1:0] r_rb_data;
  logic [XLEN-1:0] w_ra_nxt;
  logic [XLEN-1:0] w_rb_nxt;
  logic            w_run;
  logic            w_wen;
  logic            w_claim;

  assign w_run   = (r_state == S_RUN);
  // Writes and claims to the hard-wired zero register are dropped here, so
  // everything downstream can treat these strobes as final.
  assign w_wen   = w_run && rd_wen && !(ZERO_REG != 0 && rd_waddr == '0);
  assign w_claim = w_run && claim_en && !(ZERO_REG != 0 && claim_addr == '0);

  // FSM next state: CLEAR sweeps once, then RUN until the next reset.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (r_clr_cnt == LAST) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Scoreboard update. Order matters: write-clear, then claim-set (a new
  // producer supersedes the one just retiring), then flush over everything.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_run) begin
      if (rd_wen)  w_busy_nxt[rd_waddr]   = 1'b0;
      if (w_claim) w_busy_nxt[claim_addr] = 1'b1;
      if (flush)   w_busy_nxt             = '0;
    end
  end

  // Read mux per port, evaluated on the address being sampled this edge.
  // Without bypass the array still holds the pre-write value, which is
  // exactly the required old-data behaviour.
  always_comb begin
    w_ra_nxt = r_regs[ra_raddr];
    if (ZERO_REG != 0 && ra_raddr == '0)
      w_ra_nxt = '0;
    else if (BYPASS != 0 && w_wen && rd_waddr == ra_raddr)
      w_ra_nxt = rd_wdata;
  end

  always_comb begin
    w_rb_nxt = r_regs[rb_raddr];
    if (ZERO_REG != 0 && rb_raddr == '0)
      w_rb_nxt = '0;
    else if (BYPASS != 0 && w_wen && rd_waddr == rb_raddr)
      w_rb_nxt = rd_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
      r_busy    <= '0;
      r_ra_addr <= '0;
      r_rb_addr <= '0;
      r_ra_data <= '0;
      r_rb_data <= '0;
    end else begin
      r_state   <= w_state_nxt;
      if (!w_run) r_clr_cnt <= r_clr_cnt + 1'b1;
      r_busy    <= w_busy_nxt;
      r_ra_addr <= ra_raddr;
      r_rb_addr <= rb_raddr;
      r_ra_data <= w_run ? w_ra_nxt : '0;
      r_rb_data <= w_run ? w_rb_nxt : '0;
    end
  end

  // Array storage has no reset; the clear sweep initialises it instead.
  always_ff @(posedge clock) begin
    if (!w_run)
      r_regs[r_clr_cnt] <= '0;
    else if (w_wen)
      r_regs[rd_waddr] <= rd_wdata;
  end

  assign ready    = w_run;
  assign ra_rdata = r_ra_data;
  assign rb_rdata = r_rb_data;
  // Busy flags look at the live vector so a claim made at the sampling edge
  // is visible in the same cycle as the read data.
  assign ra_busy  = w_run && !(ZERO_REG != 0 && r_ra_addr == '0) && r_busy[r_ra_addr];
  assign rb_busy  = w_run && !(ZERO_REG != 0 && r_rb_addr == '0) && r_busy[r_rb_addr];

endmodule
